// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of a 4096x8 byte memory with a registered,
// one-cycle-latency read port. Sequential bytes are prefetched into a small
// byte queue. Each 16-bit instruction ({opcode, operand}) is handed to the
// decoder over a valid/ready handshake. A jump flushes the queue and drops
// any read still in flight. Fetch yields the memory whenever busGrant is low.
//
// Parameters:
//   RESET_PC   fetch/decode address loaded by reset
//   DEPTH      prefetch queue depth in bytes (power of two, >= 2)
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high reset
//   addressBus  byte address presented to memory
//   write       memory write strobe (read-only block, always 0)
//   dataBus     byte returned by memory one cycle after its address
//   busGrant    1 = fetch may issue a read this cycle
//   jumpValid   redirect request
//   jumpAddr    redirect target
//   instr       {opcode byte at instrAddr, operand byte at instrAddr+1}
//   instrAddr   address of the opcode byte
//   instrValid  instr/instrAddr valid
//   instrReady  decoder accepts instr this cycle
//   stallCount  (only with FETCH_PERF_EN) saturating count of cycles where a
//               valid instruction waited on the decoder
//
// Build option: define FETCH_PERF_EN to add the stallCount port and counter.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] addressBus,
    output logic        write,
    input  logic [7:0]  dataBus,
    input  logic        busGrant,
    input  logic        jumpValid,
    input  logic [11:0] jumpAddr,
    output logic [15:0] instr,
    output logic [11:0] instrAddr,
    output logic        instrValid,
    input  logic        instrReady
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] stallCount
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Queue depth expressed at the width of count + in-flight.
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    // Architectural state
    logic [11:0]   fetch_ptr_r;
    logic [11:0]   last_addr_r;
    logic [11:0]   decode_ptr_r;
    logic [7:0]    queue_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          inflight_r;

    // Per-cycle decisions
    logic [CW:0]   occupancy_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic [PW-1:0] head_plus1_s;
    logic [CW-1:0] count_next_s;

    assign write = 1'b0;

    // Issue/capture/pop decisions and the combinational decoder-facing view.
    always_comb begin
        occupancy_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
        // The in-flight byte already owns a queue slot, so it counts here.
        issue_s      = busGrant && !jumpValid && (occupancy_s < DEPTH_W);
        push_s       = inflight_r && !jumpValid;
        valid_s      = (count_r >= CW'(2));
        pop_s        = valid_s && instrReady;
        head_plus1_s = head_r + PW'(1);

        if (issue_s) begin
            addressBus = fetch_ptr_r;
        end else begin
            addressBus = last_addr_r;
        end

        instrValid = valid_s;
        instr      = {queue_r[head_r], queue_r[head_plus1_s]};
        instrAddr  = decode_ptr_r;
    end

    // Next occupancy: a push adds one byte, a pop removes two.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(2);
            2'b11:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy and in-flight tracking; reset beats jump beats normal flow.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_ptr_r  <= RESET_PC;
            last_addr_r  <= RESET_PC;
            decode_ptr_r <= RESET_PC;
            head_r       <= {PW{1'b0}};
            tail_r       <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            inflight_r   <= 1'b0;
        end else if (jumpValid) begin
            // Flush: drop queued bytes and the byte returning this edge.
            fetch_ptr_r  <= jumpAddr;
            decode_ptr_r <= jumpAddr;
            head_r       <= {PW{1'b0}};
            tail_r       <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            inflight_r   <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fetch_ptr_r <= fetch_ptr_r + 12'd1;
                last_addr_r <= fetch_ptr_r;
            end
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r       <= head_r + PW'(2);
                decode_ptr_r <= decode_ptr_r + 12'd2;
            end
            count_r <= count_next_s;
        end
    end

    // Byte storage; a captured byte lands in the tail slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            queue_r[tail_r] <= dataBus;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] stall_count_r;

    // Decoder back-pressure counter; saturates and survives jumps.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_r <= 16'h0000;
        end else if (valid_s && !instrReady && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end
    end

    assign stallCount = stall_count_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed scenarios for fetch_unit (RESET_PC = 0x010, DEPTH = 4) against a
// registered-read byte memory, followed by a randomized phase. The random
// phase checks the delivered instruction stream against the memory contents:
// after each jump, instructions must arrive in order from the target address,
// two bytes apart. Stalled instructions must hold steady, and the cycle after
// a jump must be empty.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [11:0] RPC = 12'h010;

    logic        clock;
    logic        reset;
    logic [11:0] addressBus;
    logic        write;
    logic [7:0]  dataBus;
    logic        busGrant;
    logic        jumpValid;
    logic [11:0] jumpAddr;
    logic [15:0] instr;
    logic [11:0] instrAddr;
    logic        instrValid;
    logic        instrReady;
`ifdef FETCH_PERF_EN
    logic [15:0] stallCount;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .addressBus (addressBus),
        .write      (write),
        .dataBus    (dataBus),
        .busGrant   (busGrant),
        .jumpValid  (jumpValid),
        .jumpAddr   (jumpAddr),
        .instr      (instr),
        .instrAddr  (instrAddr),
        .instrValid (instrValid),
        .instrReady (instrReady)
`ifdef FETCH_PERF_EN
        ,
        .stallCount (stallCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte memory with a registered read: the address seen at an edge is returned after it.
    logic [7:0] mem [4096];
    logic [7:0] mem_q;
    always @(posedge clock) mem_q <= mem[addressBus];
    assign dataBus = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive point of the next cycle (just after the rising edge).
    task automatic drive_point();
        @(posedge clock);
        #1;
    endtask

    // Advance one cycle with unchanged inputs and land on the sample point.
    task automatic step();
        drive_point();
        #1;
    endtask

    // Two reset edges, then release; returns at the sample point of cycle 0.
    task automatic do_reset(input logic ready);
        reset      = 1'b1;
        jumpValid  = 1'b0;
        jumpAddr   = 12'h000;
        busGrant   = 1'b1;
        instrReady = ready;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (instrValid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(instrValid), 32'd1);
    endtask

    function automatic logic [15:0] word_at(input logic [11:0] a);
        logic [11:0] b;
        b = a + 12'd1;
        return {mem[a], mem[b]};
    endfunction

    initial begin
        logic [11:0] exp_pc;
        logic [15:0] prev_instr;
        logic [11:0] prev_addr;
        logic        stalled;
        logic        after_jump;
        int          hs;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'hA1; mem[12'h011] = 8'h22;
        mem[12'h012] = 8'hB3; mem[12'h013] = 8'h44;
        mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22;
        mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;
        reset = 1'b1; busGrant = 1'b1; jumpValid = 1'b0; jumpAddr = 12'h000; instrReady = 1'b1;

        // ---- Basic stream after reset ----
        do_reset(1'b1);
        check("t1 reset valid", 32'(instrValid), 32'd0);
        check("t1 reset instr", 32'(instr), 32'h0000);
        check("t1 reset iaddr", 32'(instrAddr), 32'(RPC));
        check("t1 reset write", 32'(write), 32'd0);
        check("t1 addr c0", 32'(addressBus), 32'h010);
`ifdef FETCH_PERF_EN
        check("t1 reset stall", 32'(stallCount), 32'd0);
`endif
        step();
        check("t1 addr c1", 32'(addressBus), 32'h011);
        check("t1 valid c1", 32'(instrValid), 32'd0);
        step();
        check("t1 addr c2", 32'(addressBus), 32'h012);
        check("t1 valid c2", 32'(instrValid), 32'd0);
        step();
        check("t1 valid c3", 32'(instrValid), 32'd1);
        check("t1 instr c3", 32'(instr), 32'hA122);
        check("t1 iaddr c3", 32'(instrAddr), 32'h010);
        check("t1 addr c3", 32'(addressBus), 32'h013);
        step();
        check("t1 valid c4", 32'(instrValid), 32'd0);
        step();
        check("t1 valid c5", 32'(instrValid), 32'd1);
        check("t1 instr c5", 32'(instr), 32'hB344);
        check("t1 iaddr c5", 32'(instrAddr), 32'h012);

        // ---- Decoder stalled: fill exactly DEPTH bytes, hold instr ----
        do_reset(1'b0);
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) step();
            check("t2 addr", 32'(addressBus), (c < 4) ? 32'(12'h010 + 12'(c)) : 32'h013);
            if (c >= 3) begin
                check("t2 valid", 32'(instrValid), 32'd1);
                check("t2 instr", 32'(instr), 32'hA122);
                check("t2 iaddr", 32'(instrAddr), 32'h010);
            end
        end
`ifdef FETCH_PERF_EN
        check("t2 stall count", 32'(stallCount), 32'd7);
`endif

        // ---- Jump while the read of 0x013 is in flight ----
        do_reset(1'b0);
        step(); step(); step();
        check("t3 addr c3", 32'(addressBus), 32'h013);
        drive_point();
        jumpValid = 1'b1; jumpAddr = 12'h200;
        #1;
        check("t3 addr jump cycle", 32'(addressBus), 32'h013);
        drive_point();
        jumpValid = 1'b0;
        #1;
        check("t3 valid after jump", 32'(instrValid), 32'd0);
        check("t3 addr after jump", 32'(addressBus), 32'h200);
        step();
        check("t3 valid c6", 32'(instrValid), 32'd0);
        check("t3 addr c6", 32'(addressBus), 32'h201);
        step();
        check("t3 valid c7", 32'(instrValid), 32'd0);
        step();
        check("t3 valid c8", 32'(instrValid), 32'd1);
        check("t3 iaddr c8", 32'(instrAddr), 32'h200);
        check("t3 instr c8", 32'(instr), 32'(word_at(12'h200)));
`ifdef FETCH_PERF_EN
        check("t3 stall kept over jump", 32'(stallCount), 32'd2);
`endif

        // ---- busGrant low for three cycles mid-stream ----
        do_reset(1'b1);
        step();
        check("t4 addr c1", 32'(addressBus), 32'h011);
        drive_point();
        busGrant = 1'b0;
        #1;
        check("t4 addr c2", 32'(addressBus), 32'h011);
        step();
        check("t4 valid c3", 32'(instrValid), 32'd1);
        check("t4 instr c3", 32'(instr), 32'hA122);
        check("t4 addr c3", 32'(addressBus), 32'h011);
        step();
        check("t4 addr c4", 32'(addressBus), 32'h011);
        drive_point();
        busGrant = 1'b1;
        #1;
        check("t4 resume addr", 32'(addressBus), 32'h012);
        step();
        check("t4 addr c6", 32'(addressBus), 32'h013);
        step(); step();
        check("t4 valid c8", 32'(instrValid), 32'd1);
        check("t4 instr c8", 32'(instr), 32'hB344);
        check("t4 iaddr c8", 32'(instrAddr), 32'h012);

        // ---- Address wrap ----
        drive_point();
        jumpValid = 1'b1; jumpAddr = 12'hFFE;
        #1;
        drive_point();
        jumpValid = 1'b0;
        #1;
        wait_valid("t5 wait ffe", 20);
        check("t5 instr ffe", 32'(instr), 32'h1122);
        check("t5 iaddr ffe", 32'(instrAddr), 32'hFFE);
        step();
        wait_valid("t5 wait 000", 20);
        check("t5 instr 000", 32'(instr), 32'h3344);
        check("t5 iaddr 000", 32'(instrAddr), 32'h000);
        drive_point();
        jumpValid = 1'b1; jumpAddr = 12'hFFF;
        #1;
        drive_point();
        jumpValid = 1'b0;
        #1;
        wait_valid("t5 wait fff", 20);
        check("t5 instr fff", 32'(instr), 32'h2233);
        check("t5 iaddr fff", 32'(instrAddr), 32'hFFF);

        // ---- Reset with 3 queued bytes and a simultaneous jump ----
        do_reset(1'b0);
        step(); step(); step();
        drive_point();
        reset = 1'b1; jumpValid = 1'b1; jumpAddr = 12'h300;
        #1;
        drive_point();
        reset = 1'b0; jumpValid = 1'b0; instrReady = 1'b1;
        #1;
        check("t6 valid", 32'(instrValid), 32'd0);
        check("t6 addr", 32'(addressBus), 32'(RPC));
        check("t6 write", 32'(write), 32'd0);
        check("t6 iaddr", 32'(instrAddr), 32'(RPC));
`ifdef FETCH_PERF_EN
        check("t6 stall cleared", 32'(stallCount), 32'd0);
`endif
        step(); step();
        check("t6 valid c2", 32'(instrValid), 32'd0);
        step();
        check("t6 valid c3", 32'(instrValid), 32'd1);
        check("t6 instr c3", 32'(instr), 32'hA122);
        check("t6 iaddr c3", 32'(instrAddr), 32'h010);

        // ---- Randomized traffic against an in-order stream model ----
        do_reset(1'b1);
        exp_pc = RPC; stalled = 1'b0; after_jump = 1'b0; hs = 0;
        prev_instr = 16'h0000; prev_addr = 12'h000;
        for (int c = 0; c < 3000; c++) begin
            drive_point();
            busGrant   = ($urandom_range(3) != 0);
            instrReady = 1'($urandom_range(1));
            jumpValid  = ($urandom_range(31) == 0);
            jumpAddr   = 12'($urandom);
            #1;
            if (write !== 1'b0) check("rnd write", 32'(write), 32'd0);
            if (after_jump) check("rnd valid after jump", 32'(instrValid), 32'd0);
            if (stalled) begin
                check("rnd stall valid", 32'(instrValid), 32'd1);
                check("rnd stall instr", 32'(instr), 32'(prev_instr));
                check("rnd stall iaddr", 32'(instrAddr), 32'(prev_addr));
            end
            if (instrValid === 1'b1 && instrReady) begin
                check("rnd iaddr", 32'(instrAddr), 32'(exp_pc));
                check("rnd instr", 32'(instr), 32'(word_at(exp_pc)));
                exp_pc = exp_pc + 12'd2;
                hs++;
            end
            stalled    = (instrValid === 1'b1) && !instrReady && !jumpValid;
            prev_instr = instr;
            prev_addr  = instrAddr;
            after_jump = jumpValid;
            if (jumpValid) exp_pc = jumpAddr;
        end
        check("rnd progress", 32'(hs >= 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
